// File: rtl/div.sv
// div: multi-cycle radix-2 restoring divider, signed/unsigned, with annul
module div #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            signed_div_i,
  input  logic [DW-1:0]   opdata1_i,
  input  logic [DW-1:0]   opdata2_i,
  input  logic            start_i,
  input  logic            annul_i,
  output logic [2*DW-1:0] result_o,
  output logic            ready_o
);
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST = CW'(DW);
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
  state_t state, state_n;
  logic [DW-1:0] dvd, dsr, rem, abs1, abs2;
  logic [CW-1:0] cnt;
  logic neg_q, neg_r, go;
  logic [DW:0] s, d;
  assign go = start_i && !annul_i;
  assign abs1 = signed_div_i && opdata1_i[DW-1] ? -opdata1_i : opdata1_i;
  assign abs2 = signed_div_i && opdata2_i[DW-1] ? -opdata2_i : opdata2_i;
  assign s = {rem, dvd[DW-1]};
  assign d = s - {1'b0, dsr};
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= FREE;
    else state <= state_n;
  // next-state selection
  always_comb begin
    state_n = state;
    case (state)
      FREE:    state_n = go ? (opdata2_i == '0 ? BYZERO : ON) : FREE;
      BYZERO:  state_n = END;
      ON:      state_n = annul_i ? FREE : (cnt == LAST ? END : ON);
      default: state_n = start_i ? END : FREE;
    endcase
  end
  // datapath: operand latch, one quotient bit per step, sign fix-up on completion
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dvd <= '0;
      dsr <= '0;
      rem <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ready_o <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        FREE: begin
          ready_o <= 1'b0;
          result_o <= '0;
          if (go && opdata2_i != '0) begin
            dvd <= abs1;
            dsr <= abs2;
            rem <= '0;
            cnt <= '0;
            neg_q <= signed_div_i && (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
            neg_r <= signed_div_i && opdata1_i[DW-1];
          end
        end
        BYZERO: begin
          ready_o <= 1'b1;
          result_o <= '0;
        end
        ON:
          if (!annul_i) begin
            if (cnt == LAST) begin
              ready_o <= 1'b1;
              result_o <= {neg_r ? -rem : rem, neg_q ? -dvd : dvd};
            end else begin
              dvd <= {dvd[DW-2:0], ~d[DW]};
              rem <= d[DW] ? s[DW-1:0] : d[DW-1:0];
              cnt <= cnt + 1'b1;
            end
          end
        default:
          if (!start_i) begin
            ready_o <= 1'b0;
            result_o <= '0;
          end
      endcase
    end
endmodule

// File: tb/tb_div.sv
// tb_div: randomized self-checking bench for div against an arithmetic model
module tb_div;
  logic clk = 1'b0, rst = 1'b1;
  logic signed_div_i = 1'b0, start_i = 1'b0, annul_i = 1'b0;
  logic [31:0] opdata1_i = '0, opdata2_i = '0;
  logic [63:0] result_o;
  logic ready_o;
  int checks = 0, passes = 0;
  logic m_ready = 1'b0, m_zero = 1'b0;
  logic [63:0] m_res = '0, m_exp = '0;
  int m_left = 0;

  div #(.DW(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return 64'h0;
    sa = sg ? longint'($signed(a)) : longint'({32'h0, a});
    sb = sg ? longint'($signed(b)) : longint'({32'h0, b});
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // operation-level model: latency countdown, then hold the arithmetic result until start drops
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_ready = 1'b0;
      m_res = '0;
      m_left = 0;
    end else if (m_ready) begin
      if (!start_i) begin
        m_ready = 1'b0;
        m_res = '0;
      end
    end else if (m_left > 0) begin
      if (annul_i && !m_zero) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_ready = 1'b1;
          m_res = m_exp;
        end
      end
    end else if (start_i && !annul_i) begin
      m_zero = opdata2_i == 0;
      m_left = m_zero ? 1 : 33;
      m_exp = ref_div(signed_div_i, opdata1_i, opdata2_i);
    end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("cyc_ready", 64'(ready_o), 64'(m_ready));
    chk("cyc_result", result_o, m_ready ? m_res : 64'h0);
  end

  task automatic do_op(input logic sg, input logic [31:0] a, input logic [31:0] b, input int ann,
                       input bit drop, output int lat, output logic [63:0] res, output bit got);
    @(negedge clk);
    signed_div_i = sg;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1'b1;
    annul_i = 1'b0;
    lat = -1;
    res = '0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      signed_div_i = 1'($urandom);
      annul_i = 1'b0;
      if (ready_o) begin
        res = result_o;
        got = 1'b1;
        break;
      end
      if (lat == ann) begin
        annul_i = 1'b1;
        start_i = 1'b0;
      end
    end
    if (ann < 0 && !got) chk("timeout", 64'(got), 64'h1);
    if (got && drop) begin
      repeat (2) @(negedge clk);
      chk("hold", result_o, res);
      start_i = 1'b0;
      @(negedge clk);
      chk("drop_ready", 64'(ready_o), 64'h0);
      chk("drop_result", result_o, 64'h0);
    end
    start_i = 1'b0;
  endtask

  initial begin
    int lat;
    logic [63:0] res;
    bit got;
    #1;
    chk("reset_ready", 64'(ready_o), 64'h0);
    chk("reset_result", result_o, 64'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("ref_100_7", ref_div(0, 100, 7), 64'h00000002_0000000E);
    chk("ref_m7_2", ref_div(1, 32'hFFFFFFF9, 2), 64'hFFFFFFFF_FFFFFFFD);
    chk("ref_7_m2", ref_div(1, 7, 32'hFFFFFFFE), 64'h00000001_FFFFFFFD);
    chk("ref_ovf", ref_div(1, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
    chk("ref_ff_10", ref_div(0, 32'hFFFFFFFF, 32'h10), 64'h0000000F_0FFFFFFF);
    do_op(0, 100, 7, -1, 1, lat, res, got);
    chk("u100_7_lat", 64'(lat), 64'd33);
    chk("u100_7_res", res, 64'h00000002_0000000E);
    do_op(1, 32'hFFFFFFF9, 2, -1, 1, lat, res, got);
    chk("sm7_2_res", res, 64'hFFFFFFFF_FFFFFFFD);
    do_op(1, 7, 32'hFFFFFFFE, -1, 1, lat, res, got);
    chk("s7_m2_res", res, 64'h00000001_FFFFFFFD);
    do_op(0, 1234, 0, -1, 1, lat, res, got);
    chk("uzero_lat", 64'(lat), 64'd1);
    chk("uzero_res", res, 64'h0);
    do_op(1, 32'h80000000, 0, -1, 1, lat, res, got);
    chk("szero_lat", 64'(lat), 64'd1);
    chk("szero_res", res, 64'h0);
    do_op(0, 32'h12345678, 3, 9, 1, lat, res, got);
    chk("annul_no_ready", 64'(got), 64'h0);
    do_op(0, 32'hFFFFFFFF, 32'h10, -1, 1, lat, res, got);
    chk("uff_10_lat", 64'(lat), 64'd33);
    chk("uff_10_res", res, 64'h0000000F_0FFFFFFF);
    do_op(1, 32'h80000000, 32'hFFFFFFFF, -1, 1, lat, res, got);
    chk("ovf_res", res, 64'h00000000_80000000);
    @(negedge clk);
    opdata1_i = 100;
    opdata2_i = 7;
    signed_div_i = 1'b0;
    start_i = 1'b1;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_on_ready", 64'(ready_o), 64'h0);
    chk("rst_on_result", result_o, 64'h0);
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b0;
    do_op(0, 100, 7, -1, 0, lat, res, got);
    start_i = 1'b1;
    chk("end_res", res, 64'h00000002_0000000E);
    #2 rst = 1'b1;
    #1;
    chk("rst_end_ready", 64'(ready_o), 64'h0);
    chk("rst_end_result", result_o, 64'h0);
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b0;
    do_op(0, 100, 7, -1, 1, lat, res, got);
    chk("post_rst_lat", 64'(lat), 64'd33);
    chk("post_rst_res", res, 64'h00000002_0000000E);
    for (int k = 0; k < 30; k++) begin
      logic sg;
      logic [31:0] a, b;
      int ann;
      sg = 1'($urandom);
      a = $urandom;
      b = $urandom_range(0, 5) == 0 ? 32'h0 : ($urandom_range(0, 1) == 0 ? $urandom_range(1, 20) : $urandom);
      ann = $urandom_range(0, 4) == 0 ? int'($urandom_range(1, 32)) : -1;
      do_op(sg, a, b, ann, 1, lat, res, got);
      if (ann < 0) begin
        chk("rnd_lat", 64'(lat), b == 0 ? 64'd1 : 64'd33);
        chk("rnd_res", res, ref_div(sg, a, b));
      end else if (b != 0) chk("rnd_annul", 64'(got), 64'h0);
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
